dmem_responder: RTL

//  Data-memory responder for the memory stage: services memRead/memWrite requests issued by decode control.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Types and defaults shared by the dmem_responder block and its bench.
package dmem_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int AW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        RESP   = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and dmem_responder.
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) ();

    logic          mem_read;
    logic          mem_write;
    logic          halt;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          stall;
    logic          done;
    logic          err;
    logic          halted;

    modport master (
        output mem_read, mem_write, halt, addr, wdata,
        input  rdata, stall, done, err, halted
    );

    modport slave (
        input  mem_read, mem_write, halt, addr, wdata,
        output rdata, stall, done, err, halted
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: synchronous write, read data registered on read enable.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [IW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // The output register holds the last read word until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency word access with stall/done handshake and sticky halt.
// Build option: define ALIGN_CHECK_EN to reject odd byte addresses with err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int AW      = AW_DEFAULT,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_responder_if.slave bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_halt_pend, w_halt_pend_next;
    logic          r_err, w_err_next;
    op_t           r_op;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_wdata;

    logic w_req;
    logic w_misalign;
    logic w_capture;
    logic w_commit;
    logic w_stall;
    logic w_unused;

    assign w_req = bus.mem_read | bus.mem_write;

`ifdef ALIGN_CHECK_EN
    assign w_misalign = bus.addr[0];
    assign bus.err    = (r_state == RESP) & r_err;
    assign w_unused   = ^{1'b0, bus.addr[AW-1:IW+1]};
`else
    assign w_misalign = 1'b0;
    assign bus.err    = 1'b0;
    assign w_unused   = ^{r_err, bus.addr[AW-1:IW+1], bus.addr[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_halt_pend <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_halt_pend <= w_halt_pend_next;
            r_err       <= w_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_halt_pend_next = r_halt_pend;
        w_err_next       = r_err;
        w_capture        = 1'b0;
        w_commit         = 1'b0;
        w_stall          = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_capture        = 1'b1;
                    w_stall          = 1'b1;
                    w_halt_pend_next = r_halt_pend | bus.halt;
                    w_cnt_next       = CW'(LATENCY - 1);
                    w_err_next       = w_misalign;
                    w_state_next     = w_misalign ? RESP : BUSY;
                end else if (bus.halt) begin
                    w_state_next = HALTED;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (bus.halt) begin
                    w_halt_pend_next = 1'b1;
                end
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_commit     = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                // The request still held here is the one just completed.
                w_halt_pend_next = 1'b0;
                w_state_next     = (r_halt_pend | bus.halt) ? HALTED : IDLE;
            end
            HALTED: begin
                w_state_next = HALTED;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A simultaneous read+write request is treated as a write.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_op    <= bus.mem_write ? OP_WR : OP_RD;
            r_idx   <= bus.addr[IW:1];
            r_wdata <= bus.wdata;
        end
    end

    dmem_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_commit & (r_op == OP_WR)),
        .i_re    (w_commit & (r_op == OP_RD)),
        .i_addr  (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (bus.rdata)
    );

    assign bus.stall  = w_stall;
    assign bus.done   = (r_state == RESP);
    assign bus.halted = (r_state == HALTED);

endmodule
